core_sequencer: RTL

//   Per-core control FSM for the Q1.15 compute core. Steps every instruction through

---
 rtl/core_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// ---------------------------------------------------------------------------
// core_sequencer
//   Per-core control FSM for the Q1.15 compute core. Every instruction is
//   stepped through FETCH, DECODE, REQUEST, WAIT, EXECUTE and UPDATE, and the
//   current step is broadcast as core_state to the fetcher, decoder, ALUs,
//   LSUs and per-thread PC units. In UPDATE the core-wide PC is taken from the
//   lowest-index enabled lane. Lanes that disagree with that lane's next_pc
//   set a sticky divergence flag. A RET instruction ends the run in DONE.
//
// Ports
//   clk            core clock, rising edge
//   reset_n        asynchronous active-low reset
//   start          level; starts a run when sampled high in IDLE
//   thread_enable  per-lane active mask, stable during a run
//   fetcher_state  000 IDLE, 001 FETCHING, 010 FETCHED
//   lsu_state      2 bits per lane: 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE
//   decoded_ret    instruction in flight is RET
//   next_pc        per-lane next PC, lane i at [i*P +: P]
//   core_state     000 IDLE .. 111 DONE (see localparams)
//   current_pc     PC of the instruction in flight
//   done           high while core_state is DONE
//   diverged       sticky lane-disagreement flag, cleared by reset or start
// ---------------------------------------------------------------------------
module core_sequencer #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
  input  logic                                               clk,
  input  logic                                               reset_n,
  input  logic                                               start,
  input  logic [THREADS_PER_BLOCK-1:0]                       thread_enable,
  input  logic [2:0]                                         fetcher_state,
  input  logic [2*THREADS_PER_BLOCK-1:0]                     lsu_state,
  input  logic                                               decoded_ret,
  input  logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [2:0]                                         core_state,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   current_pc,
  output logic                                               done,
  output logic                                               diverged
);

  localparam int T = THREADS_PER_BLOCK;
  localparam int P = PROGRAM_MEM_ADDR_BITS;

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_FETCH   = 3'b001;
  localparam logic [2:0] S_DECODE  = 3'b010;
  localparam logic [2:0] S_REQUEST = 3'b011;
  localparam logic [2:0] S_WAIT    = 3'b100;
  localparam logic [2:0] S_EXECUTE = 3'b101;
  localparam logic [2:0] S_UPDATE  = 3'b110;
  localparam logic [2:0] S_DONE    = 3'b111;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;
  localparam logic [1:0] LSU_REQUESTING  = 2'b01;
  localparam logic [1:0] LSU_WAITING     = 2'b10;

  logic [2:0]   state_q, state_d;
  logic [P-1:0] current_pc_q, current_pc_d;
  logic         diverged_q, diverged_d;
  logic         done_q, done_d;

  logic         lsu_busy;
  logic [P-1:0] chosen_pc;
  logic         pc_mismatch;

  // A memory operation is still in flight while any enabled lane is
  // requesting or waiting; disabled lanes may show anything.
  always_comb begin
    lsu_busy = 1'b0;
    for (int i = 0; i < T; i++) begin
      if (thread_enable[i] &&
          ((lsu_state[2*i +: 2] == LSU_REQUESTING) ||
           (lsu_state[2*i +: 2] == LSU_WAITING))) begin
        lsu_busy = 1'b1;
      end
    end
  end

  // Scanning from the top lane down leaves the lowest enabled lane's PC as
  // the winner. With no lane enabled the PC simply holds.
  always_comb begin
    chosen_pc = current_pc_q;
    for (int i = T - 1; i >= 0; i--) begin
      if (thread_enable[i]) begin
        chosen_pc = next_pc[i*P +: P];
      end
    end
    pc_mismatch = 1'b0;
    for (int i = 0; i < T; i++) begin
      if (thread_enable[i] && (next_pc[i*P +: P] != chosen_pc)) begin
        pc_mismatch = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    current_pc_d = current_pc_q;
    diverged_d   = diverged_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (|thread_enable) begin
            state_d      = S_FETCH;
            current_pc_d = '0;
            diverged_d   = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (fetcher_state == FETCHER_FETCHED) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT: begin
        if (!lsu_busy) begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE: begin
        if (decoded_ret) begin
          state_d = S_DONE;
        end else begin
          state_d      = S_FETCH;
          current_pc_d = chosen_pc;
          if (pc_mismatch) begin
            diverged_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // done is registered alongside the state so it is high exactly while
  // core_state reads DONE.
  always_comb begin
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      current_pc_q <= '0;
      diverged_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      current_pc_q <= current_pc_d;
      diverged_q   <= diverged_d;
      done_q       <= done_d;
    end
  end

  assign core_state = state_q;
  assign current_pc = current_pc_q;
  assign done       = done_q;
  assign diverged   = diverged_q;

endmodule
